// File: rtl/mul_pkg.sv
// mul_pkg: shared types and helpers for the multiplication-unit job scheduler
package mul_pkg;
  typedef enum logic [2:0] {
    MM_IDLE = 3'd0,
    MM_AS   = 3'd1,
    MM_SA   = 3'd2,
    MM_SB   = 3'd3,
    MM_BS   = 3'd4
  } mem_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } sched_state_t;

  function automatic logic is_legal_mode(input logic [2:0] m);
    return m >= 3'(MM_AS) && m <= 3'(MM_BS);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or above ptr, with wrap
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = $clog2(N)
)(
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant_onehot,
  output logic [W-1:0] grant_idx,
  output logic         any
);
  logic [W-1:0] w_j;

  // Scan offsets high to low so the closest set bit above ptr wins last.
  always_comb begin
    grant_idx = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = W'((int'(ptr) + k) % N);
      if (req[w_j]) grant_idx = w_j;
    end
  end

  assign any = |req;
  assign grant_onehot = any ? N'(1) << grant_idx : '0;
endmodule

// File: rtl/mul_job_sched.sv
// mul_job_sched: round-robin front-end scheduler issuing one mode job at a time to the multiplication unit
// Define MUL_SCHED_TIMEOUT_EN to add a RUN watchdog (TIMEOUT_CYCLES) and the sticky timeout_seen output.
module mul_job_sched
  import mul_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DRAIN_CYCLES = 6
`ifdef MUL_SCHED_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT_CYCLES = 32'd200000
`endif
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [3*NREQ-1:0]       req_mode,
  output logic [NREQ-1:0]         req_ready,
  output logic [2:0]              mem_mode,
  output logic                    calc_init,
  input  logic                    calc_done,
  output logic                    busy,
  output logic                    cpl_valid,
  output logic [$clog2(NREQ)-1:0] cpl_id,
  output logic                    cpl_err,
  input  logic                    cpl_ready
`ifdef MUL_SCHED_TIMEOUT_EN
  , output logic                  timeout_seen
`endif
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("DRAIN_CYCLES must be at least 1");
  end
  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("NREQ must be in 2..4");
  end

  sched_state_t    r_state, w_next;
  logic [NREQ-1:0] r_gnt, w_onehot;
  logic [IW-1:0]   r_ptr, r_id, w_idx;
  logic [2:0]      r_mode, w_mode;
  logic [CW-1:0]   r_cnt;
  logic            r_err, w_any, w_legal, w_grant, w_to;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req(req_valid),
    .ptr(r_ptr),
    .grant_onehot(w_onehot),
    .grant_idx(w_idx),
    .any(w_any)
  );

  // Pick in IDLE; the registered req_ready cycle that follows is the grant cycle where mode is sampled.
  assign w_grant = r_state == S_IDLE && ~|r_gnt && w_any;
  assign w_mode = req_mode[3*int'(r_id) +: 3];
  assign w_legal = is_legal_mode(w_mode);

`ifdef MUL_SCHED_TIMEOUT_EN
  logic [31:0] r_to;
  logic        r_to_seen;
  assign w_to = r_state == S_RUN && !calc_done && r_to == TIMEOUT_CYCLES - 32'd1;
  assign timeout_seen = r_to_seen;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to <= '0;
      r_to_seen <= 1'b0;
    end else begin
      r_to <= r_state == S_RUN ? r_to + 32'd1 : '0;
      if (w_to) r_to_seen <= 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (|r_gnt) w_next = w_legal ? S_ISSUE : S_REPORT;
      S_ISSUE:  w_next = S_RUN;
      S_RUN:    w_next = calc_done ? S_DRAIN : w_to ? S_REPORT : S_RUN;
      S_DRAIN:  if (r_cnt == '0) w_next = S_REPORT;
      S_REPORT: if (cpl_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt <= '0;
      r_ptr <= '0;
      r_id <= '0;
      r_mode <= 3'(MM_IDLE);
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_gnt <= w_grant ? w_onehot : '0;
      if (w_grant) begin
        r_id <= w_idx;
        r_ptr <= int'(w_idx) == NREQ - 1 ? '0 : w_idx + 1'b1;
      end
      if (|r_gnt) begin
        r_mode <= w_mode;
        r_err <= !w_legal;
      end
      if (w_to) r_err <= 1'b1;
      if (r_state == S_RUN && calc_done) r_cnt <= CW'(DRAIN_CYCLES - 1);
      else if (r_state == S_DRAIN) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign req_ready = r_gnt;
  assign mem_mode = (r_state == S_ISSUE || r_state == S_RUN || r_state == S_DRAIN) ? r_mode : 3'(MM_IDLE);
  assign calc_init = r_state == S_ISSUE;
  assign busy = r_state != S_IDLE;
  assign cpl_valid = r_state == S_REPORT;
  assign cpl_id = r_id;
  assign cpl_err = r_err;
endmodule

// File: tb/tb_mul_job_sched.sv
// tb_mul_job_sched: directed and randomized job sequences checked against a round-robin job model
module tb_mul_job_sched;
  localparam int N = 2;
  localparam int D = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [3*N-1:0] req_mode;
  logic [N-1:0] req_ready;
  logic [2:0]   mem_mode;
  logic         calc_init, calc_done, busy, cpl_valid, cpl_err, cpl_ready;
  logic [$clog2(N)-1:0] cpl_id;
`ifdef MUL_SCHED_TIMEOUT_EN
  logic         timeout_seen;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int exp_ptr = 0;

  always #5 clk = ~clk;

  mul_job_sched #(
    .NREQ(N),
    .DRAIN_CYCLES(D)
`ifdef MUL_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYCLES(32'd20)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_mode(req_mode),
    .req_ready(req_ready),
    .mem_mode(mem_mode),
    .calc_init(calc_init),
    .calc_done(calc_done),
    .busy(busy),
    .cpl_valid(cpl_valid),
    .cpl_id(cpl_id),
    .cpl_err(cpl_err),
    .cpl_ready(cpl_ready)
`ifdef MUL_SCHED_TIMEOUT_EN
    , .timeout_seen(timeout_seen)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first valid requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic job(input logic [N-1:0] mask, input logic [3*N-1:0] modes, input int run_len, input int bp);
    int g;
    logic [2:0] m;
    logic legal;
    g = pick(mask, exp_ptr);
    exp_ptr = (g + 1) % N;
    m = modes[3*g +: 3];
    legal = m >= 3'd1 && m <= 3'd4;
    req_valid = mask;
    req_mode = modes;
    step();
    chk("req_ready", 32'(req_ready), 32'(1) << g);
    chk("busy_grant", 32'(busy), 0);
    step();
    req_valid[g] = 1'b0;
    req_mode = 6'($urandom);
    if (legal) begin
      chk("calc_init", 32'(calc_init), 1);
      chk("mm_issue", 32'(mem_mode), 32'(m));
      chk("busy_issue", 32'(busy), 1);
      calc_done = 1'($urandom_range(0, 1));
      step();
      calc_done = 1'b0;
      for (int i = 0; i < run_len; i++) begin
        chk("run_init", 32'(calc_init), 0);
        chk("mm_run", 32'(mem_mode), 32'(m));
        chk("run_cpl", 32'(cpl_valid), 0);
        step();
      end
      calc_done = 1'b1;
      cpl_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < D; i++) begin
        step();
        calc_done = 1'($urandom_range(0, 1));
        chk("mm_drain", 32'(mem_mode), 32'(m));
        chk("drain_cpl", 32'(cpl_valid), 0);
      end
      cpl_ready = 1'b0;
      step();
      calc_done = 1'b0;
    end
    chk("cpl_valid", 32'(cpl_valid), 1);
    chk("cpl_id", 32'(cpl_id), 32'(g));
    chk("cpl_err", 32'(cpl_err), 32'(!legal));
    chk("mm_report", 32'(mem_mode), 0);
    chk("init_report", 32'(calc_init), 0);
    cpl_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      step();
      chk("bp_valid", 32'(cpl_valid), 1);
      chk("bp_id", 32'(cpl_id), 32'(g));
      chk("bp_err", 32'(cpl_err), 32'(!legal));
      chk("bp_ready", 32'(req_ready), 0);
    end
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;
    chk("post_cpl", 32'(cpl_valid), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_mode = '0;
    calc_done = 1'b0;
    cpl_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_mm", 32'(mem_mode), 0);
    chk("rst_init", 32'(calc_init), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpl", 32'(cpl_valid), 0);
    chk("rst_id", 32'(cpl_id), 0);
    chk("rst_err", 32'(cpl_err), 0);

    // Single job, requester 0, mode SA.
    job(2'b01, {3'd0, 3'd2}, 7, 0);
    // Both always valid, mode AS: grants alternate.
    for (int j = 0; j < 4; j++) job(2'b11, {3'd1, 3'd1}, 2, 0);
    // Illegal mode from requester 1.
    job(2'b10, {3'd6, 3'd1}, 0, 0);
    // Completion back-pressure.
    job(2'b01, {3'd1, 3'd4}, 1, 5);

    // Reset three cycles after calc_init, with calc_done in the reset cycle.
    req_valid = 2'b01;
    req_mode = {3'd3, 3'd3};
    step();
    chk("rst_job_grant", 32'(req_ready), 1);
    step();
    req_valid = '0;
    chk("rst_job_init", 32'(calc_init), 1);
    step();
    step();
    step();
    rst = 1'b1;
    calc_done = 1'b1;
    step();
    rst = 1'b0;
    calc_done = 1'b0;
    exp_ptr = 0;
    chk("midrst_mm", 32'(mem_mode), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cpl", 32'(cpl_valid), 0);
    step();
    chk("midrst_idle_cpl", 32'(cpl_valid), 0);
    job(2'b11, {3'd2, 3'd4}, 3, 1);

    for (int j = 0; j < 30; j++)
      job(N'($urandom_range(1, (1 << N) - 1)), 6'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));

`ifdef MUL_SCHED_TIMEOUT_EN
    begin
      int g;
      g = pick(2'b01, exp_ptr);
      exp_ptr = (g + 1) % N;
      req_valid = 2'b01;
      req_mode = {3'd1, 3'd1};
      step();
      step();
      req_valid = '0;
      chk("to_init", 32'(calc_init), 1);
      step();
      for (int i = 0; i < 20; i++) begin
        chk("to_mm_run", 32'(mem_mode), 1);
        chk("to_run_cpl", 32'(cpl_valid), 0);
        step();
      end
      chk("to_cpl", 32'(cpl_valid), 1);
      chk("to_err", 32'(cpl_err), 1);
      chk("to_mm", 32'(mem_mode), 0);
      chk("to_seen", 32'(timeout_seen), 1);
      cpl_ready = 1'b1;
      step();
      cpl_ready = 1'b0;
      job(2'b01, {3'd2, 3'd2}, 2, 0);
      chk("to_sticky", 32'(timeout_seen), 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
